// File: rtl/eink_cmd_sequencer.sv
// E-ink command sequencer: walks a command-ROM script, feeds bytes to the SPI
// byte engine, pulses panel reset, and waits on panel busy and timed delays.
module eink_cmd_sequencer #(
  parameter int          ADDR_W       = 8,
  parameter int          DELAY_UNIT   = 50000,
  parameter int          BUSY_SETTLE  = 4,
  parameter logic [31:0] BUSY_TIMEOUT = 32'd250_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        seq_sel,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  output logic              spi_valid,
  input  logic              spi_ready,
  output logic [7:0]        spi_data,
  output logic              spi_dc,
  input  logic              spi_idle,
  input  logic              busy,
  output logic              resetb,
  output logic              active,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    SEND      = 3'd3,
    WAIT_BUSY = 3'd4,
    DELAY     = 3'd5,
    RESET_LO  = 3'd6,
    RESET_HI  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    WB_SPI    = 2'd0,
    WB_SETTLE = 2'd1,
    WB_BUSY   = 2'd2
  } wb_e;

  localparam logic [1:0]        OP_CMD  = 2'b00;
  localparam logic [1:0]        OP_DATA = 2'b01;
  localparam logic [1:0]        OP_CTRL = 2'b10;
  localparam logic [ADDR_W-3:0] OFS_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  wb_e               wb_q, wb_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [5:0]        arg_q, arg_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              spi_valid_q, spi_valid_d;
  logic [7:0]        spi_data_q, spi_data_d;
  logic              spi_dc_q, spi_dc_d;
  logic              resetb_q, resetb_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              busy_meta_q, busy_sync_q;

  logic [1:0]        op_s;
  logic [7:0]        arg_s;
  logic [31:0]       decode_cnt_s, reload_cnt_s;
  logic              last_s;
  logic [ADDR_W-1:0] adv_addr_s;
  state_e            adv_state_s;

  assign op_s         = rom_data[9:8];
  assign arg_s        = rom_data[7:0];
  assign decode_cnt_s = 32'(arg_s[5:0]) * 32'(DELAY_UNIT);
  assign reload_cnt_s = 32'(arg_q) * 32'(DELAY_UNIT);
  // Advancing from the last word of a quarter is a fault; the address stays put.
  assign last_s       = &rom_addr_q[ADDR_W-3:0];
  assign adv_addr_s   = last_s ? rom_addr_q
                               : {rom_addr_q[ADDR_W-1:ADDR_W-2], rom_addr_q[ADDR_W-3:0] + OFS_ONE};
  assign adv_state_s  = last_s ? IDLE : FETCH;

  // Next-state and registered-output logic for the script walker.
  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    cnt_d       = cnt_q;
    arg_d       = arg_q;
    rom_addr_d  = rom_addr_q;
    spi_valid_d = spi_valid_q;
    spi_data_d  = spi_data_q;
    spi_dc_d    = spi_dc_q;
    resetb_d    = resetb_q;
    active_d    = active_q;
    done_d      = 1'b0;
    error_d     = error_q;
    if (abort) begin
      state_d     = IDLE;
      spi_valid_d = 1'b0;
      resetb_d    = 1'b1;
      active_d    = 1'b0;
      error_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rom_addr_d = {seq_sel, {(ADDR_W-2){1'b0}}};
            active_d   = 1'b1;
            error_d    = 1'b0;
            state_d    = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: state_d = DECODE;
        DECODE: begin
          case (op_s)
            OP_CMD, OP_DATA: begin
              spi_data_d  = arg_s;
              spi_dc_d    = op_s[0];
              spi_valid_d = 1'b1;
              state_d     = SEND;
            end
            OP_CTRL: begin
              case (arg_s[7:6])
                2'b00: begin
                  done_d   = 1'b1;
                  active_d = 1'b0;
                  state_d  = IDLE;
                end
                2'b01: begin
                  wb_d    = WB_SPI;
                  cnt_d   = 32'd0;
                  state_d = WAIT_BUSY;
                end
                2'b10: begin
                  cnt_d   = decode_cnt_s;
                  state_d = DELAY;
                end
                default: begin
                  resetb_d = 1'b0;
                  cnt_d    = decode_cnt_s;
                  arg_d    = arg_s[5:0];
                  state_d  = RESET_LO;
                end
              endcase
            end
            default: begin
              error_d  = 1'b1;
              active_d = 1'b0;
              state_d  = IDLE;
            end
          endcase
        end
        SEND: begin
          if (spi_valid_q && spi_ready) begin
            spi_valid_d = 1'b0;
            rom_addr_d  = adv_addr_s;
            state_d     = adv_state_s;
            error_d     = error_q | last_s;
            active_d    = active_q & ~last_s;
          end else begin
            state_d = SEND;
          end
        end
        WAIT_BUSY: begin
          case (wb_q)
            WB_SPI: begin
              if (spi_idle) begin
                wb_d  = WB_SETTLE;
                cnt_d = 32'(BUSY_SETTLE);
              end else begin
                wb_d = WB_SPI;
              end
            end
            WB_SETTLE: begin
              if (cnt_q <= 32'd1) begin
                wb_d  = WB_BUSY;
                cnt_d = 32'd0;
              end else begin
                cnt_d = cnt_q - 32'd1;
              end
            end
            default: begin
              if (!busy_sync_q) begin
                rom_addr_d = adv_addr_s;
                state_d    = adv_state_s;
                error_d    = error_q | last_s;
                active_d   = active_q & ~last_s;
              end else if (cnt_q + 32'd1 == BUSY_TIMEOUT) begin
                error_d  = 1'b1;
                active_d = 1'b0;
                state_d  = IDLE;
              end else begin
                cnt_d = cnt_q + 32'd1;
              end
            end
          endcase
        end
        RESET_LO: begin
          if (cnt_q <= 32'd1) begin
            resetb_d = 1'b1;
            cnt_d    = reload_cnt_s;
            state_d  = RESET_HI;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        DELAY, RESET_HI: begin
          if (cnt_q <= 32'd1) begin
            rom_addr_d = adv_addr_s;
            state_d    = adv_state_s;
            error_d    = error_q | last_s;
            active_d   = active_q & ~last_s;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, output and busy-synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_q        <= WB_SPI;
      cnt_q       <= 32'd0;
      arg_q       <= 6'd0;
      rom_addr_q  <= {ADDR_W{1'b0}};
      spi_valid_q <= 1'b0;
      spi_data_q  <= 8'd0;
      spi_dc_q    <= 1'b0;
      resetb_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      cnt_q       <= cnt_d;
      arg_q       <= arg_d;
      rom_addr_q  <= rom_addr_d;
      spi_valid_q <= spi_valid_d;
      spi_data_q  <= spi_data_d;
      spi_dc_q    <= spi_dc_d;
      resetb_q    <= resetb_d;
      active_q    <= active_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_meta_q <= busy;
      busy_sync_q <= busy_meta_q;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign spi_valid = spi_valid_q;
  assign spi_data  = spi_data_q;
  assign spi_dc    = spi_dc_q;
  assign resetb    = resetb_q;
  assign active    = active_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
